// File: rtl/difftest_step_batcher_if.sv
// +--------------------------------------------------------------------------+
// | difftest_step_batcher_if                                                  |
// | Cycle-commit input / batched-step output bundle for the step batcher.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface difftest_step_batcher_if #(
  parameter int STEP_WIDTH = 8
);
  logic                  cycle_valid;
  logic                  flush;
  logic [7:0]            simv_result;
  logic [STEP_WIDTH-1:0] step;
  logic                  halted;
  logic [7:0]            result_code;
  logic [63:0]           total_cycles;

  modport master (
    output cycle_valid, flush, simv_result,
    input  step, halted, result_code, total_cycles
  );

  modport slave (
    input  cycle_valid, flush, simv_result,
    output step, halted, result_code, total_cycles
  );
endinterface

`default_nettype wire

// File: rtl/difftest_step_batcher.sv
// +--------------------------------------------------------------------------+
// | difftest_step_batcher                                                     |
// | Batches per-cycle commit pulses into one step emission per batch.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module difftest_step_batcher #(
  parameter int STEP_WIDTH   = 8,
  parameter int BATCH_SIZE   = 64,
  parameter int IDLE_TIMEOUT = 16
) (
  input wire logic               clock,
  input wire logic               reset,
  difftest_step_batcher_if.slave bus
);

  localparam logic [0:0] c_run    = 1'b0;
  localparam logic [0:0] c_halted = 1'b1;

  localparam int c_IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST =
    c_IDLE_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic c_TO_EN = (IDLE_TIMEOUT != 0);
  localparam logic [STEP_WIDTH:0] c_BATCH = (STEP_WIDTH + 1)'(BATCH_SIZE);

  generate
    if (BATCH_SIZE < 1 || BATCH_SIZE > (2 ** STEP_WIDTH) - 1) begin : g_bad_batch_size
      $error("difftest_step_batcher: BATCH_SIZE out of range 1..2^STEP_WIDTH-1");
    end
  endgenerate

  logic [0:0]            state_q, state_d;
  logic [STEP_WIDTH-1:0] acc_q, acc_d;
  logic [c_IDLE_W-1:0]   idle_q, idle_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  halted_q, halted_d;
  logic [7:0]            result_code_q, result_code_d;
  logic [63:0]           total_q, total_d;

  logic                  w_valid;
  logic                  w_flush;
  logic [7:0]            w_simv;
  logic [STEP_WIDTH:0]   w_acc_next;
  logic                  w_emit;

  assign w_valid    = bus.cycle_valid;
  assign w_flush    = bus.flush;
  assign w_simv     = bus.simv_result;
  // One extra bit so reaching BATCH_SIZE is observable before truncation.
  assign w_acc_next = {1'b0, acc_q} + (STEP_WIDTH + 1)'(w_valid);

  assign w_emit = (w_acc_next == c_BATCH)
               || (w_flush && (w_acc_next != '0))
               || (c_TO_EN && !w_valid && (acc_q != '0) && (idle_q == c_IDLE_LAST));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= c_run;
      acc_q         <= '0;
      idle_q        <= '0;
      step_q        <= '0;
      halted_q      <= 1'b0;
      result_code_q <= '0;
      total_q       <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      idle_q        <= idle_d;
      step_q        <= step_d;
      halted_q      <= halted_d;
      result_code_q <= result_code_d;
      total_q       <= total_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == c_run) && (w_simv != 8'd0)) begin
      state_d = c_halted;
    end
  end

  always_comb begin
    acc_d         = acc_q;
    idle_d        = idle_q;
    step_d        = '0;
    halted_d      = halted_q;
    result_code_d = result_code_q;
    total_d       = total_q;
    if (state_q == c_run) begin
      if (w_simv != 8'd0) begin
        // Final drain: the halting cycle's commit is still counted.
        if (w_acc_next != '0) begin
          step_d  = w_acc_next[STEP_WIDTH-1:0];
          total_d = total_q + 64'(w_acc_next);
        end
        acc_d         = '0;
        idle_d        = '0;
        result_code_d = w_simv;
        halted_d      = 1'b1;
      end else if (w_emit) begin
        step_d  = w_acc_next[STEP_WIDTH-1:0];
        total_d = total_q + 64'(w_acc_next);
        acc_d   = '0;
        idle_d  = '0;
      end else begin
        acc_d  = w_acc_next[STEP_WIDTH-1:0];
        idle_d = (w_valid || (w_acc_next == '0)) ? '0 : idle_q + 1'b1;
      end
    end
  end

  assign bus.step         = step_q;
  assign bus.halted       = halted_q;
  assign bus.result_code  = result_code_q;
  assign bus.total_cycles = total_q;

endmodule

`default_nettype wire

// File: tb/tb_difftest_step_batcher.sv
// +--------------------------------------------------------------------------+
// | tb_difftest_step_batcher                                                  |
// | Scoreboard bench: two batcher configurations, directed vectors.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_difftest_step_batcher;

  typedef struct {
    logic [7:0] step;
    int         cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  difftest_step_batcher_if #(.STEP_WIDTH(8)) bus_a ();
  difftest_step_batcher_if #(.STEP_WIDTH(8)) bus_b ();

  // A: batch fill / simultaneous / reset. B: idle timeout / flush / halt.
  difftest_step_batcher #(.STEP_WIDTH(8), .BATCH_SIZE(4), .IDLE_TIMEOUT(0)) u_dut_a (
    .clock (clock),
    .reset (reset_a),
    .bus   (bus_a)
  );

  difftest_step_batcher #(.STEP_WIDTH(8), .BATCH_SIZE(8), .IDLE_TIMEOUT(3)) u_dut_b (
    .clock (clock),
    .reset (reset_b),
    .bus   (bus_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic drv_a(input logic v, input logic f, input logic [7:0] exp_step);
    @(negedge clock);
    bus_a.cycle_valid = v;
    bus_a.flush       = f;
    if (exp_step != 8'd0) q_a.push_back('{exp_step, cyc + 1});
  endtask

  task automatic drv_b(input logic v, input logic f, input logic [7:0] simv,
                       input logic [7:0] exp_step);
    @(negedge clock);
    bus_b.cycle_valid = v;
    bus_b.flush       = f;
    bus_b.simv_result = simv;
    if (exp_step != 8'd0) q_b.push_back('{exp_step, cyc + 1});
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic pulse_a_reset();
    @(negedge clock);
    reset_a = 1'b1;
    bus_a.cycle_valid = 1'b0;
    bus_a.flush       = 1'b0;
    @(negedge clock);
    reset_a = 1'b0;
  endtask

  task automatic pulse_b_reset();
    @(negedge clock);
    reset_b = 1'b1;
    bus_b.cycle_valid = 1'b0;
    bus_b.flush       = 1'b0;
    bus_b.simv_result = 8'd0;
    @(negedge clock);
    reset_b = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus_a.step != 8'd0) begin
        total++;
        if (q_a.size() == 0) begin
          bad++;
          $display("FAIL a_step_unexpected: got %0d at cyc %0d, want no pulse", bus_a.step, cyc);
        end else begin
          e = q_a.pop_front();
          if (e.step !== bus_a.step || e.cyc != cyc) begin
            bad++;
            $display("FAIL a_step: got %0d at cyc %0d, want %0d at cyc %0d",
                     bus_a.step, cyc, e.step, e.cyc);
          end
        end
      end
      if (bus_b.step != 8'd0) begin
        total++;
        if (q_b.size() == 0) begin
          bad++;
          $display("FAIL b_step_unexpected: got %0d at cyc %0d, want no pulse", bus_b.step, cyc);
        end else begin
          e = q_b.pop_front();
          if (e.step !== bus_b.step || e.cyc != cyc) begin
            bad++;
            $display("FAIL b_step: got %0d at cyc %0d, want %0d at cyc %0d",
                     bus_b.step, cyc, e.step, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    repeat (3) @(negedge clock);
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clock);
    chk("a_reset_step",   64'(bus_a.step), 64'd0);
    chk("a_reset_halted", 64'(bus_a.halted), 64'd0);
    chk("a_reset_rc",     64'(bus_a.result_code), 64'd0);
    chk("a_reset_total",  bus_a.total_cycles, 64'd0);

    // Batch fill: pulses after the 4th and 8th valid, 2 left pending.
    for (int i = 1; i <= 10; i++) drv_a(1'b1, 1'b0, (i == 4 || i == 8) ? 8'd4 : 8'd0);
    drv_a(1'b0, 1'b0, 8'd0);
    chk("a_fill_total", bus_a.total_cycles, 64'd8);
    repeat (3) drv_a(1'b0, 1'b0, 8'd0);
    chk("a_no_timeout_total", bus_a.total_cycles, 64'd8);

    // acc=3 then valid+flush reaching BATCH_SIZE: single pulse of 4.
    drv_a(1'b1, 1'b0, 8'd0);
    drv_a(1'b1, 1'b1, 8'd4);
    drv_a(1'b0, 1'b0, 8'd0);
    chk("a_simul_total", bus_a.total_cycles, 64'd12);
    drv_a(1'b0, 1'b1, 8'd0);

    // Reset with acc=3: discarded, then a clean batch of 4.
    repeat (3) drv_a(1'b1, 1'b0, 8'd0);
    pulse_a_reset();
    chk("a_rst_total",  bus_a.total_cycles, 64'd0);
    chk("a_rst_step",   64'(bus_a.step), 64'd0);
    chk("a_rst_halted", 64'(bus_a.halted), 64'd0);
    for (int i = 1; i <= 4; i++) drv_a(1'b1, 1'b0, (i == 4) ? 8'd4 : 8'd0);
    drv_a(1'b0, 1'b0, 8'd0);
    chk("a_post_rst_total", bus_a.total_cycles, 64'd4);

    // Idle timeout: 2 valid, pulse of 2 decided on the 3rd idle cycle.
    drv_b(1'b1, 1'b0, 8'd0, 8'd0);
    drv_b(1'b1, 1'b0, 8'd0, 8'd0);
    drv_b(1'b0, 1'b0, 8'd0, 8'd0);
    drv_b(1'b0, 1'b0, 8'd0, 8'd0);
    drv_b(1'b0, 1'b0, 8'd0, 8'd2);
    repeat (5) drv_b(1'b0, 1'b0, 8'd0, 8'd0);
    chk("b_timeout_total", bus_b.total_cycles, 64'd2);

    // Flush together with the 4th valid.
    repeat (3) drv_b(1'b1, 1'b0, 8'd0, 8'd0);
    drv_b(1'b1, 1'b1, 8'd0, 8'd4);
    drv_b(1'b0, 1'b0, 8'd0, 8'd0);
    chk("b_flush_total",  bus_b.total_cycles, 64'd6);
    chk("b_flush_halted", 64'(bus_b.halted), 64'd0);
    drv_b(1'b0, 1'b1, 8'd0, 8'd0);

    // Halt drain from a fresh reset.
    pulse_b_reset();
    chk("b_rst_total", bus_b.total_cycles, 64'd0);
    repeat (5) drv_b(1'b1, 1'b0, 8'd0, 8'd0);
    drv_b(1'b1, 1'b0, 8'h02, 8'd6);
    drv_b(1'b0, 1'b0, 8'd0, 8'd0);
    chk("b_halt_halted", 64'(bus_b.halted), 64'd1);
    chk("b_halt_rc",     64'(bus_b.result_code), 64'h02);
    chk("b_halt_total",  bus_b.total_cycles, 64'd6);
    repeat (10) drv_b(1'b1, 1'b0, 8'd0, 8'd0);
    drv_b(1'b1, 1'b1, 8'h05, 8'd0);
    drv_b(1'b0, 1'b1, 8'd0, 8'd0);
    drv_b(1'b0, 1'b0, 8'd0, 8'd0);
    chk("b_frozen_halted", 64'(bus_b.halted), 64'd1);
    chk("b_frozen_rc",     64'(bus_b.result_code), 64'h02);
    chk("b_frozen_total",  bus_b.total_cycles, 64'd6);

    repeat (3) @(negedge clock);
  endtask

  initial begin
    bus_a.cycle_valid = 1'b0;
    bus_a.flush       = 1'b0;
    bus_a.simv_result = 8'd0;
    bus_b.cycle_valid = 1'b0;
    bus_b.flush       = 1'b0;
    bus_b.simv_result = 8'd0;
    fork
      stimulus();
      monitor();
    join_any
    disable fork;
    chk("a_pending_pulses", 64'(q_a.size()), 64'd0);
    chk("b_pending_pulses", 64'(q_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
